prog_timer_multi: RTL and testbench
===================================

Name: prog_timer_multi

Overview:
- Multi-channel, width-parametrised programmable down-counter timer; next generation of the single 8-bit programmable timer.
- Channels share one free-running prescaler driven by a base-rate strobe. Each channel independently selects its tick source: external pin, prescaler tap, or cascade from the previous channel's underflow.
- Adds one-shot mode, cascading, a per-channel underflow pulse and sticky interrupt flags. Sits beside the CPU I/O register file, which drives the config ports and consumes the flags.

Parameters:
- CHANNELS, 2: number of independent timer channels.
- WIDTH, 8: counter and reload width in bits.
- PRESCALE_BITS, 5: prescaler width; tap k is prescaler bit k-1.
- localparam SEL_W = $clog2(PRESCALE_BITS+2): width of each clock-select field.

Ports:
- clk  in  1: system clock.
- reset_n  in  1: asynchronous active-low reset.
- timebase_en  in  1: one-cycle strobe at the base rate (16,384 Hz in the current design); increments the prescaler.
- ext_in  in  CHANNELS: external tick pins, one per channel; already synchronised.
- enable  in  CHANNELS: per-channel count enable (level).
- load  in  CHANNELS: per-channel one-cycle strobe; loads the counter and arms the channel.
- one_shot  in  CHANNELS: 1 = stop after expiry; 0 = auto-reload.
- clock_sel  in  CHANNELS*SEL_W: per-channel source select; channel i uses bits [i*SEL_W +: SEL_W].
- reload_value  in  CHANNELS*WIDTH: per-channel reload value, packed the same way.
- clear_flag  in  CHANNELS: one-cycle strobe; clears the sticky flag.
- count  out  CHANNELS*WIDTH: current counter values.
- flags  out  CHANNELS: sticky expiry flags (interrupt factors).
- underflow  out  CHANNELS: registered one-cycle pulse, asserted the cycle after an expiry.
- running  out  CHANNELS: channel armed.

Behaviour:
- Reset (async, reset_n=0):
  - prescaler=0; all edge-detect history registers=0.
  - every count = all-ones; flags=0; underflow=0; running=1.
  - Reset applies at any point mid-operation; no tick, flag or pulse may be produced by reset assertion or release.
- Prescaler: free-running PRESCALE_BITS counter; +1 on each clk where timebase_en=1; wraps at all-ones to 0. It runs regardless of channel enables.
- Source decode per channel, sel = clock_sel field:
  - sel=0: ext_in[i].
  - sel=1..PRESCALE_BITS: prescaler[sel-1].
  - sel=PRESCALE_BITS+1: cascade.
  - any higher value: no source (constant 0).
- Tick generation:
  - For pin and prescaler sources, tick = falling edge, i.e. previous sample 1 and current sample 0. History registers update every cycle, even while enable=0, so re-enabling does not produce a spurious tick.
  - For cascade, tick = underflow[i-1], giving one cycle of latency per stage. Channel 0 in cascade mode never ticks.
- Effective reload R = (reload_value==0) ? all-ones : reload_value.
- Per-channel update, one action per cycle, highest priority first:
  1. load=1: count<=R; running<=1. Any tick in the same cycle is ignored.
  2. enable=1, running=1, tick=1, count<=1: expiry.
     - Auto-reload (one_shot=0): count<=R.
     - One-shot (one_shot=1): count<=0 and running<=0.
     - In both modes: flags set; underflow pulses on the next cycle.
  3. enable=1, running=1, tick=1, count>1: count<=count-1.
  4. Otherwise: count holds.
- Period: an auto-reload channel expires once every R ticks after load. Reset state (count all-ones) behaves as if loaded with all-ones.
- flags: sticky. clear_flag clears it; if an expiry and clear_flag occur in the same cycle, set wins.
- underflow is registered: it equals the expiry condition delayed one cycle and lasts exactly one cycle.
- Channel configuration changes (clock_sel, one_shot, reload_value) take effect immediately. reload_value is sampled only at load or expiry.
- Channels are fully independent apart from the shared prescaler and the cascade link.

Test Plan:
- Reset then defaults: CHANNELS=2, WIDTH=8. Pulse reset_n low mid-count -> count=0xFF/0xFF, flags=0, underflow=0, running=1 immediately (async); no underflow pulse after release.
- Auto-reload:
  - Ch0 sel=0, reload=3, load, enable=1; drive 7 falling edges on ext_in[0] -> count 3,2,1,3,2,1,3.
  - flags[0] set at the 3rd edge; underflow[0] pulses exactly one cycle after edges 3 and 6.
- One-shot: reload=2, one_shot=1, load, 4 ticks -> count 2,1,0,0; running=0 after the 2nd tick; single underflow pulse. A fresh load re-arms with count=2.
- Prescaler tap: sel=1 (prescaler bit 0), reload=0 (R=255), timebase_en every cycle -> first expiry 510 cycles after load. Toggle enable off then on across a prescaler falling edge -> that tick is lost and no extra tick appears.
- Cascade: ch0 sel=1, reload=2; ch1 sel=PRESCALE_BITS+1, reload=3 -> ch1 decrements once per ch0 underflow; ch1 expires on the 3rd ch0 underflow, one cycle after it. Ch0 itself set to cascade -> never ticks.
- Collisions:
  - load on the same cycle as a tick -> count=R, no decrement.
  - clear_flag on the same cycle as an expiry -> flag remains 1.
  - clear_flag alone -> flag=0 on the next cycle.

Source files
------------

// File: rtl/prog_timer_multi.sv
`default_nettype none
// ============================================================================
// Module      : prog_timer_multi
// Description : Multi-channel programmable down-counter timer. All channels
//               share one free-running prescaler that advances on a base-rate
//               strobe. Each channel selects its own tick source: an external
//               pin, a prescaler tap, or the underflow of the previous channel
//               (cascade). Each channel supports auto-reload or one-shot mode,
//               a sticky expiry flag and a one-cycle underflow pulse.
// Ports       :
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   timebase_en  - base-rate strobe, advances the shared prescaler
//   ext_in       - external tick pins, one per channel (already synchronised)
//   enable       - per-channel count enable (level)
//   load         - per-channel load strobe, loads counter and arms channel
//   one_shot     - per-channel mode, 1 = stop after expiry, 0 = auto-reload
//   clock_sel    - per-channel source select, SEL_W bits per channel
//   reload_value - per-channel reload value, WIDTH bits per channel
//   clear_flag   - per-channel strobe clearing the sticky flag
//   count        - current counter values, WIDTH bits per channel
//   flags        - sticky expiry flags
//   underflow    - one-cycle pulse in the cycle after an expiry
//   running      - channel armed
// Revision    : 1.0 - initial release
// ============================================================================
module prog_timer_multi #(
  parameter  int CHANNELS      = 2,
  parameter  int WIDTH         = 8,
  parameter  int PRESCALE_BITS = 5,
  localparam int SEL_W         = $clog2(PRESCALE_BITS + 2)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      timebase_en,
  input  logic [CHANNELS-1:0]       ext_in,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       one_shot,
  input  logic [CHANNELS*SEL_W-1:0] clock_sel,
  input  logic [CHANNELS*WIDTH-1:0] reload_value,
  input  logic [CHANNELS-1:0]       clear_flag,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       flags,
  output logic [CHANNELS-1:0]       underflow,
  output logic [CHANNELS-1:0]       running
);

  localparam logic [SEL_W-1:0] c_SEL_CASCADE = SEL_W'(PRESCALE_BITS + 1);

  logic [PRESCALE_BITS-1:0] prescaler_q;
  logic [CHANNELS-1:0]      underflow_q;

  // Shared prescaler; free-running, independent of channel enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_q <= '0;
    end else if (timebase_en) begin
      prescaler_q <= prescaler_q + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SEL_W-1:0] sel_w;
    logic [WIDTH-1:0] reload_w;
    logic [WIDTH-1:0] reload_eff_w;
    logic             src_w;
    logic             cascade_w;
    logic             tick_w;
    logic             expire_w;

    logic [WIDTH-1:0] count_q, count_d;
    logic             hist_q;
    logic             flag_q, flag_d;
    logic             run_q, run_d;

    assign sel_w    = clock_sel[i*SEL_W +: SEL_W];
    assign reload_w = reload_value[i*WIDTH +: WIDTH];

    // A reload value of zero would never expire; treat it as the full range.
    assign reload_eff_w = (reload_w == '0) ? '1 : reload_w;

    // Edge-detected source: pin for sel 0, prescaler tap k for sel k.
    // Cascade and out-of-range selects feed a constant 0 into the history.
    always_comb begin
      src_w = 1'b0;
      if (sel_w == '0) begin
        src_w = ext_in[i];
      end
      for (int k = 0; k < PRESCALE_BITS; k++) begin
        if (sel_w == SEL_W'(k + 1)) begin
          src_w = prescaler_q[k];
        end
      end
    end

    if (i == 0) begin : g_first
      assign cascade_w = 1'b0;
    end else begin : g_chain
      assign cascade_w = underflow_q[i-1];
    end

    // History keeps sampling while disabled so re-enabling sees no stale edge.
    assign tick_w = (sel_w == c_SEL_CASCADE) ? cascade_w : (hist_q & ~src_w);

    assign expire_w = !load[i] && enable[i] && run_q && tick_w &&
                      (count_q <= WIDTH'(1));

    always_comb begin
      count_d = count_q;
      run_d   = run_q;
      if (load[i]) begin
        count_d = reload_eff_w;
        run_d   = 1'b1;
      end else if (expire_w) begin
        if (one_shot[i]) begin
          count_d = '0;
          run_d   = 1'b0;
        end else begin
          count_d = reload_eff_w;
        end
      end else if (enable[i] && run_q && tick_w) begin
        count_d = count_q - 1'b1;
      end
      // Set dominates clear when both happen together.
      flag_d = expire_w ? 1'b1 : (clear_flag[i] ? 1'b0 : flag_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_q        <= '1;
        hist_q         <= 1'b0;
        flag_q         <= 1'b0;
        run_q          <= 1'b1;
        underflow_q[i] <= 1'b0;
      end else begin
        count_q        <= count_d;
        hist_q         <= src_w;
        flag_q         <= flag_d;
        run_q          <= run_d;
        underflow_q[i] <= expire_w;
      end
    end

    assign count[i*WIDTH +: WIDTH] = count_q;
    assign flags[i]                = flag_q;
    assign running[i]              = run_q;
  end

  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_timer_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_timer_multi
// Description : Self-checking bench for prog_timer_multi (2 channels, 8 bit).
//               A vector table drives channel 0 through auto-reload, flag
//               clear and load/tick collisions; hand-written sequences cover
//               one-shot, prescaler taps, enable gating, cascade and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_timer_multi;

  localparam int CH    = 2;
  localparam int W     = 8;
  localparam int PB    = 5;
  localparam int SEL_W = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              timebase_en;
  logic [CH-1:0]     ext_in, enable, load, one_shot, clear_flag;
  logic [CH*SEL_W-1:0] clock_sel;
  logic [CH*W-1:0]   reload_value;
  logic [CH*W-1:0]   count;
  logic [CH-1:0]     flags, underflow, running;

  int checks   = 0;
  int failures = 0;
  int uf0_cnt  = 0;

  prog_timer_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_BITS(PB)) dut (
    .clk(clk), .reset_n(reset_n), .timebase_en(timebase_en),
    .ext_in(ext_in), .enable(enable), .load(load), .one_shot(one_shot),
    .clock_sel(clock_sel), .reload_value(reload_value),
    .clear_flag(clear_flag), .count(count), .flags(flags),
    .underflow(underflow), .running(running)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (underflow[0]) uf0_cnt++;

  typedef struct {
    logic       ext;
    logic       ld;
    logic       clr;
    logic [7:0] cnt;
    logic       flg;
    logic       uf;
    logic       run;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pres_inc();
    timebase_en = 1'b1;
    step();
    timebase_en = 1'b0;
    step();
  endtask

  task automatic ext_edge();
    ext_in[0] = 1'b1;
    step();
    ext_in[0] = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    int first_flag, first_uf, base;
    reset_n = 1'b1; timebase_en = 1'b0; ext_in = '0; enable = '0; load = '0;
    one_shot = '0; clear_flag = '0; clock_sel = {3'd7, 3'd0};
    reload_value = {8'd0, 8'd3};

    // ---------------- reset state ----------------
    #1;
    do_reset();
    chk("rst_count", count, 16'hFFFF);
    chk("rst_flags", flags, 2'b00);
    chk("rst_uf", underflow, 2'b00);
    chk("rst_running", running, 2'b11);

    // ---------------- table: ch0 auto-reload, R=3 ----------------
    //              ext   ld    clr   cnt    flg   uf    run
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b1}; // edge 3: expiry
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1}; // clear alone
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b1}; // edge 6: set beats clear
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1}; // edge 7
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1}; // load + tick
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1};

    enable[0] = 1'b1;
    for (int v = 0; v < 18; v++) begin
      ext_in[0] = vecs[v].ext; load[0] = vecs[v].ld; clear_flag[0] = vecs[v].clr;
      step();
      chk($sformatf("tbl%0d_count", v), count[7:0], vecs[v].cnt);
      chk($sformatf("tbl%0d_flag", v), flags[0], vecs[v].flg);
      chk($sformatf("tbl%0d_uf", v), underflow[0], vecs[v].uf);
      chk($sformatf("tbl%0d_run", v), running[0], vecs[v].run);
    end
    load = '0; clear_flag = '0; ext_in = '0;

    // ---------------- one-shot, R=2 ----------------
    do_reset();
    one_shot[0] = 1'b1; reload_value[7:0] = 8'd2; enable[0] = 1'b1;
    load[0] = 1'b1; step(); load[0] = 1'b0;
    chk("os_load", count[7:0], 8'd2);
    base = uf0_cnt;
    ext_edge(); chk("os_t1", count[7:0], 8'd1);
    ext_edge(); chk("os_t2", count[7:0], 8'd0);
    chk("os_run_t2", running[0], 1'b0);
    ext_edge(); chk("os_t3", count[7:0], 8'd0);
    ext_edge(); chk("os_t4", count[7:0], 8'd0);
    step();
    chk("os_uf_pulses", uf0_cnt - base, 1);
    load[0] = 1'b1; step(); load[0] = 1'b0;
    chk("os_rearm_cnt", count[7:0], 8'd2);
    chk("os_rearm_run", running[0], 1'b1);
    one_shot = '0;

    // ---------------- prescaler tap 1, R=255 ----------------
    do_reset();
    clock_sel[2:0] = 3'd1; reload_value[7:0] = 8'd0; enable[0] = 1'b1;
    load[0] = 1'b1; timebase_en = 1'b1; step(); load[0] = 1'b0;
    chk("ps_load", count[7:0], 8'd255);
    first_flag = -1; first_uf = -1;
    for (int n = 1; n <= 600 && first_uf < 0; n++) begin
      step();
      if (flags[0] && first_flag < 0) first_flag = n;
      if (underflow[0] && first_uf < 0) first_uf = n;
    end
    timebase_en = 1'b0;
    chk("ps_first_flag", first_flag, 510);
    chk("ps_first_uf", first_uf, 510);

    // ---------------- enable gating across a prescaler edge ----------------
    do_reset();
    clock_sel[2:0] = 3'd1; reload_value[7:0] = 8'd10; enable[0] = 1'b1;
    load[0] = 1'b1; step(); load[0] = 1'b0;
    pres_inc(); pres_inc();
    chk("en_tick", count[7:0], 8'd9);
    enable[0] = 1'b0;
    pres_inc(); pres_inc();
    chk("en_lost", count[7:0], 8'd9);
    enable[0] = 1'b1;
    step();
    chk("en_no_spurious", count[7:0], 8'd9);
    pres_inc(); pres_inc();
    chk("en_resume", count[7:0], 8'd8);

    // ---------------- cascade ----------------
    do_reset();
    clock_sel = {3'd6, 3'd1}; reload_value = {8'd3, 8'd2}; enable = 2'b11;
    load = 2'b11; step(); load = '0;
    chk("cas_load", count, {8'd3, 8'd2});
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) pres_inc();
      chk($sformatf("cas_r%0d_uf0", r), underflow[0], 1'b1);
      chk($sformatf("cas_r%0d_pre", r), count[15:8], 8'(3 - r));
      step();
      if (r < 2) begin
        chk($sformatf("cas_r%0d_post", r), count[15:8], 8'(2 - r));
      end else begin
        chk("cas_expire_cnt", count[15:8], 8'd3);
        chk("cas_expire_flag", flags[1], 1'b1);
        chk("cas_expire_uf", underflow[1], 1'b1);
      end
    end

    // ---------------- asynchronous reset mid-operation ----------------
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", count, 16'hFFFF);
    chk("arst_flags", flags, 2'b00);
    chk("arst_uf", underflow, 2'b00);
    chk("arst_running", running, 2'b11);
    @(negedge clk);
    reset_n = 1'b1;
    base = 0;
    for (int s = 0; s < 3; s++) begin
      step();
      if (underflow != 2'b00) base++;
    end
    chk("arst_no_pulse", base, 0);
    chk("arst_hold", count, 16'hFFFF);

    // ---------------- channel 0 in cascade mode never ticks ----------------
    clock_sel[2:0] = 3'd6;
    for (int p = 0; p < 4; p++) pres_inc();
    chk("cas0_never", count[7:0], 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
